shift_sequencer: RTL and testbench

- Multi-cycle shift unit for the CPU datapath: shifts a 32-bit word by a variable amount 0..31 using one fixed shift-by-2 stage, plus a shift-by-1 stage for odd amounts.
- Sequences the fixed stage over several cycles instead of instantiating a full barrel shifter.
- Serves SLL/SRL-class instructions through a Start/Busy/Done handshake with the control unit.

---
 rtl/shift_sequencer_if.sv | 36 +++
 rtl/shift_sequencer.sv | 134 +++++++++++++
 tb/tb_shift_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Start/Busy/Done handshake bundle between the control unit and the shift sequencer.
// master = control unit (drives Start/InData/ShAmt/Dir[/Arith]); slave = shift_sequencer.
interface shift_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [WIDTH-1:0] InData;
    logic [4:0]       ShAmt;
    logic             Dir;
`ifdef SHIFT_ARITH_EN
    logic             Arith;
`endif
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] OutData;

`ifdef SHIFT_ARITH_EN
    modport master (
        output Start, InData, ShAmt, Dir, Arith,
        input  Busy, Done, OutData
    );
    modport slave (
        input  Start, InData, ShAmt, Dir, Arith,
        output Busy, Done, OutData
    );
`else
    modport master (
        output Start, InData, ShAmt, Dir,
        input  Busy, Done, OutData
    );
    modport slave (
        input  Start, InData, ShAmt, Dir,
        output Busy, Done, OutData
    );
`endif
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one shift-by-2 stage (plus a final shift-by-1 for odd amounts)
// iterated over several cycles, driven through a Start/Busy/Done handshake.
// Ports: CLK, Reset (sync, active-high), bus (shift_sequencer_if.slave):
//   Start/InData/ShAmt/Dir in, Busy/Done/OutData out.
// Optional macro SHIFT_ARITH_EN adds bus.Arith for sign-filling right shifts.
module shift_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic            CLK,
    input  logic            Reset,
    shift_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] data_shift;
    logic [4:0]       rem;
    logic [4:0]       rem_nxt;
    logic             dir;
    logic             fill;

`ifdef SHIFT_ARITH_EN
    logic arith;
    // An arithmetic right shift never changes the MSB, so the live
    // register MSB equals the latched operand's sign bit.
    assign fill = dir & arith & data[WIDTH-1];
`else
    assign fill = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Remaining count after this cycle's step
    always_comb begin
        rem_nxt = 5'd0;
        if (rem >= 5'd2) begin
            rem_nxt = rem - 5'd2;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.Start) begin
                    state_nxt = (bus.ShAmt != 5'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (rem_nxt == 5'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        bus.Busy    = (state == RUN) || (state == DONE);
        bus.Done    = (state == DONE);
        bus.OutData = data;
    end

    // One step of the shift datapath: by 2 unless only one bit is left
    always_comb begin
        data_shift = data;
        if (rem >= 5'd2) begin
            if (dir) begin
                data_shift = {{2{fill}}, data[WIDTH-1:2]};
            end else begin
                data_shift = {data[WIDTH-3:0], 2'b00};
            end
        end else if (rem == 5'd1) begin
            if (dir) begin
                data_shift = {fill, data[WIDTH-1:1]};
            end else begin
                data_shift = {data[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Working register, remaining count and latched controls
    always_ff @(posedge CLK) begin
        if (Reset) begin
            data  <= '0;
            rem   <= 5'd0;
            dir   <= 1'b0;
`ifdef SHIFT_ARITH_EN
            arith <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.Start) begin
                        data  <= bus.InData;
                        rem   <= bus.ShAmt;
                        dir   <= bus.Dir;
`ifdef SHIFT_ARITH_EN
                        arith <= bus.Arith;
`endif
                    end
                end
                RUN: begin
                    data <= data_shift;
                    rem  <= rem_nxt;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
// Covers reset, latency, left/right shifts, busy-start rejection, back-to-back and mid-op reset.
module tb_shift_sequencer;

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    shift_sequencer_if #(.WIDTH(32)) bus ();

    shift_sequencer #(.WIDTH(32)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the following posedge accepts the request.
    task automatic start_op(input logic [31:0] din, input logic [4:0] amt,
                            input logic d, input logic a);
        bus.Start  = 1'b1;
        bus.InData = din;
        bus.ShAmt  = amt;
        bus.Dir    = d;
`ifdef SHIFT_ARITH_EN
        bus.Arith  = a;
`else
        if (a) begin
        end
`endif
        @(posedge CLK);
        #1;
        bus.Start  = 1'b0;
    endtask

    // Counts cycles after the accepting edge until Done, bounded.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (!bus.Busy) busy_ok = 1'b0;
            if (bus.Done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] din,
                          input logic [4:0] amt, input logic d, input logic a,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        bit bok;
        start_op(din, amt, d, a);
        wait_done(lat, bok);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_out"}, bus.OutData, exp);
        chk({tag, "_busy"}, {31'b0, bok}, 32'd1);
        @(negedge CLK);
        chk({tag, "_idle"}, {30'b0, bus.Busy, bus.Done}, 32'd0);
        chk({tag, "_hold"}, bus.OutData, exp);
    endtask

    initial begin
        int lat;
        int ndone;
        int d1;
        int d2;
        bit bok;

        bus.Start  = 1'b0;
        bus.InData = '0;
        bus.ShAmt  = '0;
        bus.Dir    = 1'b0;
`ifdef SHIFT_ARITH_EN
        bus.Arith  = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        chk("rst_busy", {31'b0, bus.Busy}, 32'd0);
        chk("rst_done", {31'b0, bus.Done}, 32'd0);
        chk("rst_out", bus.OutData, 32'd0);
        Reset = 1'b0;
        @(negedge CLK);

        run_op("l2", 32'h0000_0001, 5'd2, 1'b0, 1'b0, 32'h0000_0004, 2);
        run_op("z0", 32'h1234_5678, 5'd0, 1'b0, 1'b0, 32'h1234_5678, 1);
        run_op("l31", 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 32'h8000_0000, 17);
        run_op("r5", 32'h8000_0000, 5'd5, 1'b1, 1'b0, 32'h0400_0000, 4);
        run_op("r1", 32'hF0F0_F0F0, 5'd1, 1'b1, 1'b0, 32'h7878_7878, 2);
        run_op("l4", 32'hA5A5_A5A5, 5'd4, 1'b0, 1'b0, 32'h5A5A_5A50, 3);
        run_op("r31", 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001, 17);
`ifdef SHIFT_ARITH_EN
        run_op("ar5", 32'h8000_0000, 5'd5, 1'b1, 1'b1, 32'hFC00_0000, 4);
        run_op("ar5p", 32'h4000_0000, 5'd5, 1'b1, 1'b1, 32'h0200_0000, 4);
        run_op("al3", 32'h8000_0001, 5'd3, 1'b0, 1'b1, 32'h0000_0008, 3);
`endif

        // Start asserted while busy must be ignored
        start_op(32'h0000_0003, 5'd6, 1'b0, 1'b0);
        ndone = 0;
        d1 = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLK);
            if (i == 1) begin
                bus.Start  = 1'b1;
                bus.InData = 32'hFFFF_FFFF;
                bus.ShAmt  = 5'd1;
            end
            if (bus.Done) begin
                ndone++;
                if (d1 == 0) d1 = i;
                bus.Start = 1'b0;
            end
        end
        chk("busy_st_ndone", ndone, 1);
        chk("busy_st_lat", d1, 4);
        chk("busy_st_out", bus.OutData, 32'h0000_00C0);

        // Start held high: re-accepted in the first IDLE cycle
        start_op(32'h0000_0001, 5'd1, 1'b0, 1'b0);
        bus.Start = 1'b1;
        d1 = 0;
        d2 = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            if (i == 3) begin
                chk("b2b_idle", {31'b0, bus.Busy}, 32'd0);
            end
            if (bus.Done) begin
                if (d1 == 0) begin
                    d1 = i;
                    chk("b2b_out1", bus.OutData, 32'h0000_0002);
                    bus.InData = 32'h0000_0010;
                    bus.ShAmt  = 5'd3;
                    bus.Dir    = 1'b1;
                end else if (d2 == 0) begin
                    d2 = i;
                    chk("b2b_out2", bus.OutData, 32'h0000_0002);
                    bus.Start = 1'b0;
                end
            end
        end
        bus.Start = 1'b0;
        bus.Dir   = 1'b0;
        chk("b2b_d1", d1, 2);
        chk("b2b_d2", d2, 6);
        @(negedge CLK);

        // Reset during RUN discards the operation
        start_op(32'h0000_0001, 5'd20, 1'b0, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        chk("mrst_busy", {31'b0, bus.Busy}, 32'd0);
        chk("mrst_done", {31'b0, bus.Done}, 32'd0);
        chk("mrst_out", bus.OutData, 32'd0);
        Reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (bus.Done) ndone++;
        end
        chk("mrst_nodone", ndone, 0);
        run_op("post", 32'h0000_0003, 5'd3, 1'b0, 1'b0, 32'h0000_0018, 3);

        // Inputs changing after acceptance have no effect
        start_op(32'h0000_00FF, 5'd4, 1'b1, 1'b0);
        bus.InData = 32'hDEAD_BEEF;
        bus.ShAmt  = 5'd17;
        bus.Dir    = 1'b0;
        wait_done(lat, bok);
        chk("chg_lat", lat, 3);
        chk("chg_out", bus.OutData, 32'h0000_000F);
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
